// File: rtl/mem_access_ctrl.sv
// Memory access sequencer between the control unit (mfa/moc handshake) and a byte-addressed RAM.
// Latency: mfa to moc is at least 4 edges (IDLE, SETUP, ACCESS, DONE); misaligned requests finish in 1 edge.
// Backpressure: waits in ACCESS for ram_moc, and holds moc in DONE until mfa drops. Optional MEM_TIMEOUT_EN bounds the wait.
module mem_access_ctrl #(
    parameter int ADDR_W         = 7,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    // control-unit request
    input  logic              mfa,
    input  logic              rw,
    input  logic [1:0]        size,
    input  logic              signed_ld,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [31:0]       wdata_in,
    // RAM side
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_data,
    output logic              ram_w_r,
    output logic              ram_enable,
    output logic [1:0]        ram_mode,
    input  logic              ram_moc,
    input  logic [31:0]       ram_rdata,
    // control-unit response
    output logic [31:0]       rdata,
    output logic              moc,
    output logic              busy,
    output logic              align_err,
    output logic              timeout
);

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // A zero-length wait window would make the bounded ACCESS wait meaningless.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_cycles_check
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t              state_q;
    state_t              state_d;

    // Request latched in IDLE; RAM-facing outputs are driven straight from these.
    logic                req_rw_q;
    logic [1:0]          req_size_q;
    logic                req_signed_q;
    logic [ADDR_W-1:0]   req_addr_q;
    logic [31:0]         req_wdata_q;

    logic [31:0]         rdata_q;
    logic                align_err_q;

    logic                req_misaligned;
    logic                accept_req;
    logic                set_align_err;
    logic                set_timeout;
    logic                capture_rd;
    logic                wait_expired;

    // Illegal size or an address that does not sit on the access-size boundary.
    always_comb begin
        req_misaligned = 1'b0;
        case (size)
            SIZE_BYTE: req_misaligned = 1'b0;
            SIZE_HALF: req_misaligned = addr_in[0];
            SIZE_WORD: req_misaligned = (addr_in[1:0] != 2'b00);
            default:   req_misaligned = 1'b1;
        endcase
    end

    // Right-justified RAM data is narrowed to the access size and zero/sign-extended.
    function automatic logic [31:0] format_load(input logic [1:0]  sz,
                                                input logic        sgn,
                                                input logic [31:0] d);
        logic [31:0] res;
        case (sz)
            SIZE_BYTE: res = {{24{sgn & d[7]}}, d[7:0]};
            SIZE_HALF: res = {{16{sgn & d[15]}}, d[15:0]};
            default:   res = d;
        endcase
        return res;
    endfunction

`ifdef MEM_TIMEOUT_EN
    // Counter wide enough for TIMEOUT_CYCLES, never narrower than 5 bits.
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 5) ? $clog2(TIMEOUT_CYCLES + 1) : 5;

    logic [CNT_W-1:0] wait_cnt_q;
    logic             timeout_q;

    // Last ACCESS cycle of the window: leaving on this edge makes TIMEOUT_CYCLES ACCESS cycles in total.
    assign wait_expired = (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Counts ACCESS cycles; held at zero elsewhere so every ACCESS entry starts from zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
        end else if (state_q != S_ACCESS) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
        end
    end

    // Timeout flag lives for the DONE phase of the timed-out access only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timeout_q <= 1'b0;
        end else if (set_timeout) begin
            timeout_q <= 1'b1;
        end else if (state_q == S_DONE && !mfa) begin
            timeout_q <= 1'b0;
        end
    end

    assign timeout = timeout_q;
`else
    // Without the timeout option ACCESS waits for ram_moc indefinitely.
    assign wait_expired = 1'b0;
    assign timeout      = 1'b0;
`endif

    // Next-state logic; ram_moc wins over an expiring wait on the same edge.
    always_comb begin
        state_d       = state_q;
        accept_req    = 1'b0;
        set_align_err = 1'b0;
        set_timeout   = 1'b0;
        capture_rd    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mfa) begin
                    accept_req = 1'b1;
                    if (req_misaligned) begin
                        set_align_err = 1'b1;
                        state_d       = S_DONE;
                    end else begin
                        state_d       = S_SETUP;
                    end
                end
            end
            S_SETUP: begin
                // RAM lines settle for one cycle before enable; ram_moc is not looked at here.
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (ram_moc) begin
                    capture_rd = req_rw_q;
                    state_d    = S_DONE;
                end else if (wait_expired) begin
                    set_timeout = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (!mfa) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register; reset also aborts an access in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request fields are captured only when a request is accepted, so later input changes are ignored.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_rw_q     <= 1'b1;
            req_size_q   <= 2'b00;
            req_signed_q <= 1'b0;
            req_addr_q   <= '0;
            req_wdata_q  <= '0;
        end else if (accept_req) begin
            req_rw_q     <= rw;
            req_size_q   <= size;
            req_signed_q <= signed_ld;
            req_addr_q   <= addr_in;
            req_wdata_q  <= wdata_in;
        end
    end

    // Load result only moves on a completed read; writes, errors and timeouts leave it alone.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (capture_rd) begin
            rdata_q <= format_load(req_size_q, req_signed_q, ram_rdata);
        end
    end

    // Alignment error is reported through DONE and cleared as the handshake closes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            align_err_q <= 1'b0;
        end else if (set_align_err) begin
            align_err_q <= 1'b1;
        end else if (state_q == S_DONE && !mfa) begin
            align_err_q <= 1'b0;
        end
    end

    assign ram_addr   = req_addr_q;
    assign ram_data   = req_wdata_q;
    assign ram_w_r    = req_rw_q;
    assign ram_mode   = req_size_q;
    assign ram_enable = (state_q == S_ACCESS);

    assign rdata      = rdata_q;
    assign moc        = (state_q == S_DONE);
    assign busy       = (state_q != S_IDLE);
    assign align_err  = align_err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed requests against a byte RAM, with a transaction-level reference model.
// The compare process checks outputs 1ns after every rising edge; literal checks pin the model's results.
// RAM answers ram_moc one edge after it sees enable; a stall switch holds ram_moc low.
module tb_mem_access_ctrl;

    localparam int ADDR_W = 7;
    localparam int TO     = 16;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic              mfa       = 1'b0;
    logic              rw        = 1'b1;
    logic [1:0]        size      = 2'b00;
    logic              signed_ld = 1'b0;
    logic [ADDR_W-1:0] addr_in   = '0;
    logic [31:0]       wdata_in  = '0;

    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_data;
    logic              ram_w_r;
    logic              ram_enable;
    logic [1:0]        ram_mode;
    logic              ram_moc   = 1'b0;
    logic [31:0]       ram_rdata = '0;
    logic [31:0]       rdata;
    logic              moc;
    logic              busy;
    logic              align_err;
    logic              timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .mfa(mfa), .rw(rw), .size(size), .signed_ld(signed_ld),
        .addr_in(addr_in), .wdata_in(wdata_in), .ram_addr(ram_addr), .ram_data(ram_data),
        .ram_w_r(ram_w_r), .ram_enable(ram_enable), .ram_mode(ram_mode), .ram_moc(ram_moc),
        .ram_rdata(ram_rdata), .rdata(rdata), .moc(moc), .busy(busy), .align_err(align_err),
        .timeout(timeout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- RAM stimulus model ----------------
    logic [7:0] ram_mem [0:127];
    logic       stall = 1'b0;

    // Acts on every enabled edge; completion is reported one edge later.
    always @(posedge clk) begin
        ram_moc <= ram_enable && !stall;
        if (ram_enable) begin
            if (!ram_w_r) begin
                ram_mem[ram_addr] <= ram_data[7:0];
                if (ram_mode != 2'b00) ram_mem[ram_addr + 7'd1] <= ram_data[15:8];
                if (ram_mode == 2'b10) begin
                    ram_mem[ram_addr + 7'd2] <= ram_data[23:16];
                    ram_mem[ram_addr + 7'd3] <= ram_data[31:24];
                end
            end else begin
                case (ram_mode)
                    2'b00:   ram_rdata <= {24'h0, ram_mem[ram_addr]};
                    2'b01:   ram_rdata <= {16'h0, ram_mem[ram_addr + 7'd1], ram_mem[ram_addr]};
                    default: ram_rdata <= {ram_mem[ram_addr + 7'd3], ram_mem[ram_addr + 7'd2],
                                           ram_mem[ram_addr + 7'd1], ram_mem[ram_addr]};
                endcase
            end
        end
    end

    // ---------------- reference model ----------------
    logic [7:0]  ref_mem [0:127];
    logic        req_active = 1'b0;
    logic        moc_seen   = 1'b0;
    int          req_edges  = 0;
    int          exp_lat    = 0;
    logic        m_rw, m_sgn, m_err, exp_to;
    logic [1:0]  m_size;
    logic [6:0]  m_addr;
    logic [31:0] m_wdata;
    logic [31:0] exp_rdata = '0;

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] s, input logic sg, input logic [6:0] a);
        logic [31:0] v;
        int n;
        n = nbytes(s);
        v = '0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[7'(int'(a) + i)]) << (8 * i));
        if (sg && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    // Per-cycle comparison against the model.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            req_active = 1'b0;
            moc_seen   = 1'b0;
            exp_rdata  = '0;
            check("rst_enable", 32'(ram_enable), 32'd0);
            check("rst_moc", 32'(moc), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_w_r", 32'(ram_w_r), 32'd1);
            check("rst_flags", {30'd0, align_err, timeout}, 32'd0);
            check("rst_rdata", rdata, 32'd0);
        end else begin
            if (!req_active && mfa) begin
                req_active = 1'b1;
                moc_seen   = 1'b0;
                req_edges  = 0;
                m_rw = rw; m_size = size; m_sgn = signed_ld; m_addr = addr_in; m_wdata = wdata_in;
                m_err = (size == 2'b11) || (size == 2'b01 && addr_in[0]) ||
                        (size == 2'b10 && addr_in[1:0] != 2'b00);
`ifdef MEM_TIMEOUT_EN
                exp_to  = !m_err && stall;
                exp_lat = m_err ? 1 : (stall ? 2 + TO : 4);
`else
                exp_to  = 1'b0;
                exp_lat = m_err ? 1 : 4;
`endif
            end
            if (req_active && !moc_seen) begin
                req_edges++;
                if (moc) begin
                    moc_seen = 1'b1;
                    check("moc_latency", 32'(req_edges), 32'(exp_lat));
                    if (!m_err && !exp_to) begin
                        if (m_rw) exp_rdata = model_load(m_size, m_sgn, m_addr);
                        else for (int i = 0; i < nbytes(m_size); i++)
                            ref_mem[7'(int'(m_addr) + i)] = m_wdata[8 * i +: 8];
                    end
                end
            end
            if (req_active && moc_seen && !moc) begin
                req_active = 1'b0;
                check("release_busy", 32'(busy), 32'd0);
            end
            if (!req_active) check("idle_moc", 32'(moc), 32'd0);
            check("align_err", 32'(align_err), 32'(req_active && moc_seen && m_err));
            check("timeout", 32'(timeout), 32'(req_active && moc_seen && exp_to));
            check("rdata", rdata, exp_rdata);
            if (ram_enable) begin
                check("enable_legal", {30'd0, m_err, moc_seen}, 32'd0);
                check("ram_addr", 32'(ram_addr), 32'(m_addr));
                check("ram_mode", 32'(ram_mode), 32'(m_size));
                check("ram_w_r", 32'(ram_w_r), 32'(m_rw));
                check("ram_data", ram_data, m_wdata);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic start_req(input logic r, input logic [1:0] s, input logic sg,
                             input logic [6:0] a, input logic [31:0] d);
        @(negedge clk);
        rw = r; size = s; signed_ld = sg; addr_in = a; wdata_in = d; mfa = 1'b1;
        // Inputs change while busy; the latched request must not follow them.
        @(negedge clk);
        rw = ~r; size = ~s; signed_ld = ~sg; addr_in = ~a; wdata_in = ~d;
    endtask

    task automatic wait_moc(input int limit);
        int n;
        n = 0;
        while (!moc && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("moc_wait", 32'(moc), 32'd1);
    endtask

    task automatic finish_req(input int hold);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("moc_hold", {30'd0, moc, ram_enable}, 32'd2);
        end
        mfa = 1'b0;
        @(negedge clk);
        check("drop_busy", 32'(busy), 32'd0);
        check("drop_moc", 32'(moc), 32'd0);
    endtask

    task automatic do_req(input logic r, input logic [1:0] s, input logic sg,
                          input logic [6:0] a, input logic [31:0] d, input int hold);
        start_req(r, s, sg, a, d);
        wait_moc(40);
        finish_req(hold);
    endtask

    task automatic pulse_reset(input int n);
        @(negedge clk);
        rst_n = 1'b0;
        mfa   = 1'b0;
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            ram_mem[i] = 8'(i * 7 + 3);
            ref_mem[i] = 8'(i * 7 + 3);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // byte store then signed / unsigned byte loads
        do_req(1'b0, 2'b00, 1'b0, 7'd5, 32'hAAAA_AA80, 0);
        do_req(1'b1, 2'b00, 1'b1, 7'd5, 32'h0, 0);
        check("byte_signed", rdata, 32'hFFFF_FF80);
        do_req(1'b1, 2'b00, 1'b0, 7'd5, 32'h0, 0);
        check("byte_unsigned", rdata, 32'h0000_0080);

        // halfword store then unsigned / signed loads
        do_req(1'b0, 2'b01, 1'b0, 7'd4, 32'h1234_BEEF, 0);
        do_req(1'b1, 2'b01, 1'b0, 7'd4, 32'h0, 0);
        check("half_unsigned", rdata, 32'h0000_BEEF);
        do_req(1'b1, 2'b01, 1'b1, 7'd4, 32'h0, 0);
        check("half_signed", rdata, 32'hFFFF_BEEF);

        // word store, then load with mfa held 10 cycles past moc
        do_req(1'b0, 2'b10, 1'b0, 7'd8, 32'h1234_5678, 0);
        do_req(1'b1, 2'b10, 1'b0, 7'd8, 32'h0, 10);
        check("word_load", rdata, 32'h1234_5678);
        do_req(1'b1, 2'b00, 1'b1, 7'd8, 32'h0, 0);
        check("byte_pos_signed", rdata, 32'h0000_0078);
        do_req(1'b1, 2'b10, 1'b0, 7'd8, 32'h0, 0);

        // misaligned word: immediate DONE with align_err, RAM untouched
        start_req(1'b1, 2'b10, 1'b0, 7'd6, 32'h0);
        wait_moc(10);
        check("mis_align_err", 32'(align_err), 32'd1);
        check("mis_no_enable", 32'(ram_enable), 32'd0);
        check("mis_rdata", rdata, 32'h1234_5678);
        finish_req(0);
        check("mis_cleared", 32'(align_err), 32'd0);

        // odd halfword and illegal size
        do_req(1'b1, 2'b01, 1'b0, 7'd3, 32'h0, 2);
        do_req(1'b0, 2'b11, 1'b0, 7'd0, 32'hDEAD_BEEF, 0);
        do_req(1'b1, 2'b00, 1'b0, 7'd0, 32'h0, 0);
        check("illegal_no_write", rdata, 32'h0000_0003);

        // reset in the middle of ACCESS, then a normal request
        stall = 1'b1;
        start_req(1'b1, 2'b10, 1'b0, 7'd8, 32'h0);
        repeat (4) @(negedge clk);
        check("pre_reset_access", {30'd0, ram_enable, busy}, 32'd3);
        pulse_reset(1);
        stall = 1'b0;
        check("post_reset_rdata", rdata, 32'd0);
        do_req(1'b1, 2'b10, 1'b0, 7'd8, 32'h0, 0);
        check("after_reset_load", rdata, 32'h1234_5678);

        // RAM never answers
        stall = 1'b1;
        start_req(1'b1, 2'b10, 1'b0, 7'd12, 32'h0);
`ifdef MEM_TIMEOUT_EN
        wait_moc(40);
        check("timeout_flag", 32'(timeout), 32'd1);
        check("timeout_rdata", rdata, 32'h1234_5678);
        finish_req(0);
        stall = 1'b0;
`else
        repeat (40) @(negedge clk);
        check("stall_busy", {30'd0, busy, moc}, 32'd2);
        check("stall_timeout", 32'(timeout), 32'd0);
        pulse_reset(1);
        stall = 1'b0;
`endif
        do_req(1'b1, 2'b01, 1'b0, 7'd4, 32'h0, 0);
        check("final_half", rdata, 32'h0000_BEEF);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
